// File: rtl/wb_arbiter_2.sv
//==============================================================================
// Module   : wb_arbiter_2
// Purpose  : Two-master Wishbone arbiter sharing one slave bus.
//            Master 0 is instruction fetch, master 1 is data access.
//            Grants are held until the owner drops cyc (no preemption).
//            A released grant hands over directly to a waiting master.
// Options  : Define WB_ARB_RR_EN for round-robin selection on simultaneous
//            requests. Without it master 1 always wins (fixed priority).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module wb_arbiter_2 #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,

    // Master 0 (instruction fetch)
    input  logic                    m0_wb_cyc_i,
    input  logic                    m0_wb_stb_i,
    input  logic                    m0_wb_we_i,
    input  logic [ADDR_WIDTH-1:0]   m0_wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   m0_wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0] m0_wb_sel_i,
    output logic                    m0_wb_ack_o,
    output logic [DATA_WIDTH-1:0]   m0_wb_dat_o,

    // Master 1 (data memory access)
    input  logic                    m1_wb_cyc_i,
    input  logic                    m1_wb_stb_i,
    input  logic                    m1_wb_we_i,
    input  logic [ADDR_WIDTH-1:0]   m1_wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   m1_wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0] m1_wb_sel_i,
    output logic                    m1_wb_ack_o,
    output logic [DATA_WIDTH-1:0]   m1_wb_dat_o,

    // Shared slave bus
    output logic                    s_wb_cyc_o,
    output logic                    s_wb_stb_o,
    output logic                    s_wb_we_o,
    output logic [ADDR_WIDTH-1:0]   s_wb_adr_o,
    output logic [DATA_WIDTH-1:0]   s_wb_dat_o,
    output logic [DATA_WIDTH/8-1:0] s_wb_sel_o,
    input  logic                    s_wb_ack_i,
    input  logic [DATA_WIDTH-1:0]   s_wb_dat_i,

    // One-hot grant, straight from the state register
    output logic [1:0]              grant_o
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;

    // Encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        GRANT_M0 = 2'b01,
        GRANT_M1 = 2'b10
    } state_e;

    state_e state_q;
    state_e state_d;
    state_e both_pick;

    // 0 = master 0 granted most recently, 1 = master 1.
    logic   last_grant_q;
    logic   last_grant_d;

    // Low for the first edge after reset release; keeps the first grant
    // off that edge so reset deassertion never coincides with a grant.
    logic   armed_q;

    // Winner when both masters request while idle.
`ifdef WB_ARB_RR_EN
    assign both_pick = last_grant_q ? GRANT_M0 : GRANT_M1;
`else
    assign both_pick = GRANT_M1;
`endif

    // Arbitration enable: set on the first rising edge out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= 1'b1;
        end
    end

    // State and last-grant registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next-state: hold the owner while its cyc is high, otherwise hand over
    // to a waiting master or fall back to idle.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;

        case (state_q)
            IDLE: begin
                if (armed_q) begin
                    if (m0_wb_cyc_i && m1_wb_cyc_i) begin
                        state_d = both_pick;
                    end else if (m0_wb_cyc_i) begin
                        state_d = GRANT_M0;
                    end else if (m1_wb_cyc_i) begin
                        state_d = GRANT_M1;
                    end
                end
            end
            GRANT_M0: begin
                if (!m0_wb_cyc_i) begin
                    state_d = m1_wb_cyc_i ? GRANT_M1 : IDLE;
                end
            end
            GRANT_M1: begin
                if (!m1_wb_cyc_i) begin
                    state_d = m0_wb_cyc_i ? GRANT_M0 : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Record the owner on each fresh entry into a grant state.
        if ((state_d == GRANT_M0) && (state_q != GRANT_M0)) begin
            last_grant_d = 1'b0;
        end else if ((state_d == GRANT_M1) && (state_q != GRANT_M1)) begin
            last_grant_d = 1'b1;
        end
    end

    // Bus routing: granted master drives the slave, slave ack goes back only
    // to the owner. Idle drives everything to zero and swallows stray acks.
    always_comb begin
        s_wb_cyc_o  = 1'b0;
        s_wb_stb_o  = 1'b0;
        s_wb_we_o   = 1'b0;
        s_wb_adr_o  = '0;
        s_wb_dat_o  = '0;
        s_wb_sel_o  = {SEL_WIDTH{1'b0}};
        m0_wb_ack_o = 1'b0;
        m1_wb_ack_o = 1'b0;

        case (state_q)
            GRANT_M0: begin
                s_wb_cyc_o  = m0_wb_cyc_i;
                s_wb_stb_o  = m0_wb_stb_i;
                s_wb_we_o   = m0_wb_we_i;
                s_wb_adr_o  = m0_wb_adr_i;
                s_wb_dat_o  = m0_wb_dat_i;
                s_wb_sel_o  = m0_wb_sel_i;
                m0_wb_ack_o = s_wb_ack_i;
            end
            GRANT_M1: begin
                s_wb_cyc_o  = m1_wb_cyc_i;
                s_wb_stb_o  = m1_wb_stb_i;
                s_wb_we_o   = m1_wb_we_i;
                s_wb_adr_o  = m1_wb_adr_i;
                s_wb_dat_o  = m1_wb_dat_i;
                s_wb_sel_o  = m1_wb_sel_i;
                m1_wb_ack_o = s_wb_ack_i;
            end
            default: begin
            end
        endcase
    end

    // Read data is broadcast; masters qualify it with their own ack.
    assign m0_wb_dat_o = s_wb_dat_i;
    assign m1_wb_dat_o = s_wb_dat_i;

    assign grant_o = state_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter_2.sv
//==============================================================================
// Module   : tb_wb_arbiter_2
// Purpose  : Self-checking bench for wb_arbiter_2: directed scenarios with
//            literal expectations, then randomized traffic checked against
//            an ownership model. Build with WB_ARB_RR_EN to match the DUT.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_wb_arbiter_2;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [AW-1:0] m0_adr, m1_adr;
    logic [DW-1:0] m0_wdat, m1_wdat;
    logic [SW-1:0] m0_sel, m1_sel;
    logic          m0_ack, m1_ack;
    logic [DW-1:0] m0_rdat, m1_rdat;
    logic          s_cyc, s_stb, s_we;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_wdat;
    logic [SW-1:0] s_sel;
    logic          s_ack;
    logic [DW-1:0] s_rdat;
    logic [1:0]    grant;

    int checks   = 0;
    int failures = 0;

    wb_arbiter_2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .m0_wb_cyc_i(m0_cyc), .m0_wb_stb_i(m0_stb), .m0_wb_we_i(m0_we),
        .m0_wb_adr_i(m0_adr), .m0_wb_dat_i(m0_wdat), .m0_wb_sel_i(m0_sel),
        .m0_wb_ack_o(m0_ack), .m0_wb_dat_o(m0_rdat),
        .m1_wb_cyc_i(m1_cyc), .m1_wb_stb_i(m1_stb), .m1_wb_we_i(m1_we),
        .m1_wb_adr_i(m1_adr), .m1_wb_dat_i(m1_wdat), .m1_wb_sel_i(m1_sel),
        .m1_wb_ack_o(m1_ack), .m1_wb_dat_o(m1_rdat),
        .s_wb_cyc_o(s_cyc), .s_wb_stb_o(s_stb), .s_wb_we_o(s_we),
        .s_wb_adr_o(s_adr), .s_wb_dat_o(s_wdat), .s_wb_sel_o(s_sel),
        .s_wb_ack_i(s_ack), .s_wb_dat_i(s_rdat),
        .grant_o(grant)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: who owns the bus ----------------
    // owner: 0 none, 1 master 0, 2 master 1. last: most recent owner.
    int owner = 0;
    int last  = 2;
    bit seen_edge = 1'b0;

    function automatic int next_owner(input int cur, input int lst, input bit r1, input bit r2);
        bit req [1:2];
        req[1] = r1;
        req[2] = r2;
        if (cur != 0 && req[cur]) return cur;
        if (cur != 0) return req[3-cur] ? 3 - cur : 0;
        if (r1 && r2) begin
`ifdef WB_ARB_RR_EN
            return 3 - lst;
`else
            return 2;
`endif
        end
        if (r1) return 1;
        if (r2) return 2;
        return 0;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner     <= 0;
            last      <= 2;
            seen_edge <= 1'b0;
        end else if (!seen_edge) begin
            seen_edge <= 1'b1;
        end else begin
            int nxt;
            nxt = next_owner(owner, last, m0_cyc, m1_cyc);
            owner <= nxt;
            if (nxt != 0) last <= nxt;
        end
    end

    // Compare process: outputs are checked mid-low-phase every cycle.
    always @(negedge clk) begin
        #2;
        begin
            logic [1:0]    e_grant;
            logic          e_cyc, e_stb, e_we;
            logic [AW-1:0] e_adr;
            logic [DW-1:0] e_dat;
            logic [SW-1:0] e_sel;
            e_grant = (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00;
            e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
            e_adr = '0; e_dat = '0; e_sel = '0;
            if (owner == 1) begin
                e_cyc = m0_cyc; e_stb = m0_stb; e_we = m0_we;
                e_adr = m0_adr; e_dat = m0_wdat; e_sel = m0_sel;
            end else if (owner == 2) begin
                e_cyc = m1_cyc; e_stb = m1_stb; e_we = m1_we;
                e_adr = m1_adr; e_dat = m1_wdat; e_sel = m1_sel;
            end
            check("mdl_grant", grant, e_grant);
            check("mdl_s_cyc", s_cyc, e_cyc);
            check("mdl_s_stb", s_stb, e_stb);
            check("mdl_s_we",  s_we,  e_we);
            check("mdl_s_adr", s_adr, e_adr);
            check("mdl_s_dat", s_wdat, e_dat);
            check("mdl_s_sel", s_sel, e_sel);
            check("mdl_m0_ack", m0_ack, (owner == 1) && s_ack);
            check("mdl_m1_ack", m1_ack, (owner == 2) && s_ack);
            check("mdl_m0_dat", m0_rdat, s_rdat);
            check("mdl_m1_dat", m1_rdat, s_rdat);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_wdat = '0; m0_sel = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_wdat = '0; m1_sel = '0;
        s_ack = 0; s_rdat = '0;

        // Reset held low with both masters requesting and a stray ack.
        #1 reset = 1'b0;
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h8000_0000; m0_sel = 4'hF;
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h8040_0000; m1_sel = 4'hF;
        s_ack = 1;
        repeat (3) begin
            @(negedge clk); #3;
            check("rst_grant", grant, 2'b00);
            check("rst_s_cyc", s_cyc, 1'b0);
            check("rst_m0_ack", m0_ack, 1'b0);
            check("rst_m1_ack", m1_ack, 1'b0);
        end

        // Release with both requesting: two edges before the first grant.
        @(negedge clk); reset = 1'b1; s_ack = 0; #3;
        check("rel_grant_n0", grant, 2'b00);
        @(negedge clk); #3;
        check("rel_grant_n1", grant, 2'b00);
        @(negedge clk); #3;
`ifdef WB_ARB_RR_EN
        check("both_grant", grant, 2'b01);
        check("both_adr", s_adr, 32'h8000_0000);
`else
        check("both_grant", grant, 2'b10);
        check("both_adr", s_adr, 32'h8040_0000);
`endif
        @(negedge clk); m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        @(negedge clk); #3;
        check("drop_grant", grant, 2'b00);

        // Master 0 read, ack two cycles after the grant.
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h8000_0000; m0_sel = 4'hF;
        @(negedge clk); #3;
        check("rd_grant", grant, 2'b01);
        check("rd_adr", s_adr, 32'h8000_0000);
        check("rd_ack_early", m0_ack, 1'b0);
        @(negedge clk);
        @(negedge clk); s_ack = 1; s_rdat = 32'h0000_0013; #3;
        check("rd_m0_ack", m0_ack, 1'b1);
        check("rd_m0_dat", m0_rdat, 32'h0000_0013);
        check("rd_m1_ack", m1_ack, 1'b0);
        @(negedge clk); s_ack = 0; #3;
        check("rd_ack_one", m0_ack, 1'b0);

        // Master 1 write waits behind master 0, then takes over directly.
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_sel = 4'b0001;
        m1_wdat = 32'h0000_00AB; m1_adr = 32'h0000_1000;
        repeat (2) begin
            @(negedge clk); s_ack = 1; #3;
            check("wait_grant", grant, 2'b01);
            check("wait_m1_ack", m1_ack, 1'b0);
            check("wait_s_we", s_we, 1'b0);
        end
        @(negedge clk); s_ack = 0; m0_cyc = 0; m0_stb = 0;
        @(negedge clk); #3;
        check("sw_grant", grant, 2'b10);
        check("sw_we", s_we, 1'b1);
        check("sw_sel", s_sel, 4'b0001);
        check("sw_dat", s_wdat, 32'h0000_00AB);

        // Reset mid-transaction, late ack after release.
        @(negedge clk); #1 reset = 1'b0; #1;
        check("mid_s_cyc", s_cyc, 1'b0);
        check("mid_s_stb", s_stb, 1'b0);
        check("mid_grant", grant, 2'b00);
        @(negedge clk); reset = 1'b1; s_ack = 1; #3;
        check("late_m1_ack", m1_ack, 1'b0);
        check("late_m0_ack", m0_ack, 1'b0);
        @(negedge clk); #3;
        check("late_m1_ack2", m1_ack, 1'b0);
        check("late_grant", grant, 2'b00);
        s_ack = 0; m1_cyc = 0; m1_stb = 0;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 3) == 0) m0_cyc = ~m0_cyc;
            if ($urandom_range(0, 3) == 0) m1_cyc = ~m1_cyc;
            m0_stb = 1'($urandom); m0_we = 1'($urandom);
            m0_adr = $urandom; m0_wdat = $urandom; m0_sel = 4'($urandom);
            m1_stb = 1'($urandom); m1_we = 1'($urandom);
            m1_adr = $urandom; m1_wdat = $urandom; m1_sel = 4'($urandom);
            s_ack = 1'($urandom); s_rdat = $urandom;
        end

        @(negedge clk); #5;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
